// File: rtl/ray_hit_resolve_if.sv
// Ray hit resolve bus: issue side, per-axis compare results, result stream.
// Status outputs (in_stall, overflow) travel with the bus.
interface ray_hit_resolve_if #(
    parameter int ID_W = 8
);
    logic            in_valid;
    logic [ID_W-1:0] in_id;
    logic            le_x;
    logic            le_y;
    logic            le_z;
    logic            in_stall;
    logic            out_valid;
    logic            out_ready;
    logic [ID_W-1:0] out_id;
    logic            out_hit;
    logic            overflow;

    modport master (
        output in_valid,
        output in_id,
        output le_x,
        output le_y,
        output le_z,
        output out_ready,
        input  in_stall,
        input  out_valid,
        input  out_id,
        input  out_hit,
        input  overflow
    );

    modport slave (
        input  in_valid,
        input  in_id,
        input  le_x,
        input  le_y,
        input  le_z,
        input  out_ready,
        output in_stall,
        output out_valid,
        output out_id,
        output out_hit,
        output overflow
    );
endinterface

// File: rtl/ray_hit_resolve.sv
// Ray/box hit resolver: tag delay line, AND of per-axis results, output FIFO.
// Optional feature macro RAY_HIT_COUNT_EN adds a saturating hit_count output.
module ray_hit_resolve #(
    parameter int LAT   = 5,
    parameter int ID_W  = 8,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    ray_hit_resolve_if.slave    bus
`ifdef RAY_HIT_COUNT_EN
    ,
    output logic [15:0]         hit_count
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + LAT + 1) + 1;

    logic [LAT:1]    dl_vld;
    logic [ID_W-1:0] dl_id [1:LAT];

    logic [ID_W:0]   mem [DEPTH];
    logic [AW:0]     wptr;
    logic [AW:0]     rptr;
    logic [AW:0]     count;
    logic            empty;
    logic            full;
    logic            push;
    logic            push_hit;
    logic            pop;
    logic            wr_en;
    logic            drop;
    logic [ID_W:0]   head;
    logic [CW-1:0]   free;
    logic [CW-1:0]   inflight;
    logic            ovf;

    // Tag delay line: advances every cycle, mirrors the comparator latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dl_vld <= '0;
            for (int i = 1; i <= LAT; i++) begin
                dl_id[i] <= '0;
            end
        end else begin
            dl_vld[1] <= bus.in_valid;
            dl_id[1]  <= bus.in_id;
            for (int i = 2; i <= LAT; i++) begin
                dl_vld[i] <= dl_vld[i-1];
                dl_id[i]  <= dl_id[i-1];
            end
        end
    end

    // FIFO control: push from last delay stage, pop on accepted head.
    always_comb begin
        count    = wptr - rptr;
        empty    = (wptr == rptr);
        full     = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
        push     = dl_vld[LAT];
        push_hit = bus.le_x & bus.le_y & bus.le_z;
        pop      = !empty & bus.out_ready;
        wr_en    = push & (!full | pop);
        drop     = push & full & !pop;
    end

    // FIFO storage; contents are only observed through valid pointers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr[AW-1:0]] <= {dl_id[LAT], push_hit};
        end
    end

    // Pointers carry a wrap bit so full and empty stay distinguishable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // Sticky drop flag: a resolved ray found the FIFO full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end
    end

    // Stall when in-flight rays could exceed the remaining FIFO space.
    always_comb begin
        inflight = '0;
        for (int i = 1; i <= LAT; i++) begin
            inflight = inflight + CW'(dl_vld[i]);
        end
        free = CW'(DEPTH) - CW'(count);
    end

    // Head presentation; fields forced to zero while the FIFO is empty.
    always_comb begin
        head          = mem[rptr[AW-1:0]];
        bus.out_valid = !empty;
        bus.out_id    = empty ? '0 : head[ID_W:1];
        bus.out_hit   = !empty & head[0];
        bus.in_stall  = (free <= inflight);
        bus.overflow  = ovf;
    end

`ifdef RAY_HIT_COUNT_EN
    // Saturating count of delivered hits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count <= '0;
        end else if (pop && head[0] && hit_count != 16'hFFFF) begin
            hit_count <= hit_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ray_hit_resolve.sv
// Directed bench for ray_hit_resolve (LAT=5, ID_W=8, DEPTH=4).
// Define RAY_HIT_COUNT_EN to also exercise hit_count saturation.
module tb_ray_hit_resolve;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
`ifdef RAY_HIT_COUNT_EN
    logic [15:0] hit_count;
`endif

    ray_hit_resolve_if #(.ID_W(8)) ifc ();

    ray_hit_resolve #(.LAT(5), .ID_W(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (ifc)
`ifdef RAY_HIT_COUNT_EN
        ,
        .hit_count (hit_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifc.in_valid  = 1'b0;
        ifc.in_id     = '0;
        ifc.le_x      = 1'b0;
        ifc.le_y      = 1'b0;
        ifc.le_z      = 1'b0;
        ifc.out_ready = 1'b0;
    endtask

    task automatic set_le(input logic [2:0] v);
        ifc.le_x = v[2];
        ifc.le_y = v[1];
        ifc.le_z = v[0];
    endtask

    task automatic do_reset();
        idle();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        #2;
        checks++;
        if (ifc.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %0b want 0", ifc.out_valid);
        end
        checks++;
        if (ifc.in_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_stall got %0b want 0", ifc.in_stall);
        end
        checks++;
        if (ifc.out_id !== 8'h00 || ifc.out_hit !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_data got %h/%0b want 00/0",
                     ifc.out_id, ifc.out_hit);
        end
        checks++;
        if (ifc.overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_overflow got %0b want 0", ifc.overflow);
        end
`ifdef RAY_HIT_COUNT_EN
        checks++;
        if (hit_count !== 16'h0000) begin
            errors++;
            $display("FAIL reset_hit_count got %h want 0000", hit_count);
        end
`endif
        do_reset();
    endtask

    task automatic test_single();
        for (int c = 0; c <= 8; c++) begin
            ifc.out_ready = 1'b1;
            ifc.in_valid  = (c == 0);
            ifc.in_id     = 8'h12;
            set_le((c == 5) ? 3'b111 : 3'b000);
            checks++;
            if (ifc.out_valid !== (c == 6)) begin
                errors++;
                $display("FAIL single_valid c=%0d got %0b want %0b",
                         c, ifc.out_valid, (c == 6));
            end
            if (c == 6) begin
                checks++;
                if (ifc.out_id !== 8'h12 || ifc.out_hit !== 1'b1) begin
                    errors++;
                    $display("FAIL single_data got %h/%0b want 12/1",
                             ifc.out_id, ifc.out_hit);
                end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_id;
        do_reset();
        for (int c = 0; c <= 16; c++) begin
            ifc.out_ready = 1'b1;
            ifc.in_valid  = (c < 8);
            ifc.in_id     = 8'(c);
            ifc.le_x      = 1'b1;
            ifc.le_z      = 1'b1;
            ifc.le_y      = (c >= 5) ? ((c - 5) % 2 == 0) : 1'b0;
            checks++;
            if (ifc.out_valid !== (c >= 6 && c < 14)) begin
                errors++;
                $display("FAIL b2b_valid c=%0d got %0b", c, ifc.out_valid);
            end
            if (c >= 6 && c < 14) begin
                exp_id = 8'(c - 6);
                checks++;
                if (ifc.out_id !== exp_id ||
                    ifc.out_hit !== ((c - 6) % 2 == 0)) begin
                    errors++;
                    $display("FAIL b2b_data c=%0d got %h/%0b want %h/%0b",
                             c, ifc.out_id, ifc.out_hit, exp_id,
                             ((c - 6) % 2 == 0));
                end
            end
            tick();
        end
        checks++;
        if (ifc.overflow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_overflow got %0b want 0", ifc.overflow);
        end
        idle();
    endtask

    task automatic test_stall();
        int issued = 0;
        int got = 0;
        logic [7:0] exp_id;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            ifc.out_ready = 1'b0;
            set_le(3'b111);
            checks++;
            if (ifc.in_stall !== (c >= 4)) begin
                errors++;
                $display("FAIL stall_flag c=%0d got %0b want %0b",
                         c, ifc.in_stall, (c >= 4));
            end
            ifc.in_valid = !ifc.in_stall;
            ifc.in_id    = 8'(8'h40 + issued);
            if (!ifc.in_stall) begin
                issued++;
            end
            tick();
        end
        ifc.in_valid = 1'b0;
        checks++;
        if (issued != 4) begin
            errors++;
            $display("FAIL stall_issued got %0d want 4", issued);
        end
        checks++;
        if (ifc.overflow !== 1'b0) begin
            errors++;
            $display("FAIL stall_overflow got %0b want 0", ifc.overflow);
        end
        ifc.out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (ifc.out_valid === 1'b1) begin
                exp_id = 8'(8'h40 + got);
                checks++;
                if (ifc.out_id !== exp_id) begin
                    errors++;
                    $display("FAIL stall_order n=%0d got %h want %h",
                             got, ifc.out_id, exp_id);
                end
                got++;
            end
            tick();
        end
        checks++;
        if (got != 4) begin
            errors++;
            $display("FAIL stall_delivered got %0d want 4", got);
        end
        idle();
    endtask

    task automatic test_overflow();
        int got = 0;
        logic [7:0] exp_id;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            ifc.out_ready = 1'b0;
            ifc.in_valid  = (c < 5);
            ifc.in_id     = 8'(8'h50 + c);
            set_le((c == 6) ? 3'b011 : 3'b111);
            checks++;
            if (ifc.overflow !== (c >= 10)) begin
                errors++;
                $display("FAIL ovf_flag c=%0d got %0b want %0b",
                         c, ifc.overflow, (c >= 10));
            end
            tick();
        end
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (ifc.out_valid === 1'b1) begin
                exp_id = 8'(8'h50 + got);
                checks++;
                if (ifc.out_id !== exp_id || ifc.out_hit !== (got != 1)) begin
                    errors++;
                    $display("FAIL ovf_content n=%0d got %h/%0b want %h/%0b",
                             got, ifc.out_id, ifc.out_hit, exp_id,
                             (got != 1));
                end
                got++;
            end
            tick();
        end
        checks++;
        if (got != 4) begin
            errors++;
            $display("FAIL ovf_delivered got %0d want 4", got);
        end
        checks++;
        if (ifc.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got %0b want 1", ifc.overflow);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 7; c++) begin
            ifc.out_ready = 1'b0;
            ifc.in_valid  = (c < 5);
            ifc.in_id     = 8'(8'h60 + c);
            set_le(3'b111);
            tick();
        end
        ifc.in_valid = 1'b0;
        checks++;
        if (ifc.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_valid got %0b want 1", ifc.out_valid);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ifc.out_valid !== 1'b0 || ifc.out_id !== 8'h00 ||
            ifc.in_stall !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_out got v=%0b id=%h st=%0b want 0/00/0",
                     ifc.out_valid, ifc.out_id, ifc.in_stall);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();
        ifc.out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            checks++;
            if (ifc.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_ghost c=%0d got %0b want 0",
                         c, ifc.out_valid);
            end
            tick();
        end
        for (int c = 0; c <= 7; c++) begin
            ifc.in_valid = (c == 0);
            ifc.in_id    = 8'h77;
            set_le((c == 5) ? 3'b111 : 3'b000);
            checks++;
            if (ifc.out_valid !== (c == 6) ||
                (c == 6 && ifc.out_id !== 8'h77)) begin
                errors++;
                $display("FAIL mid_first c=%0d got %0b/%h want %0b/77",
                         c, ifc.out_valid, ifc.out_id, (c == 6));
            end
            tick();
        end
        idle();
    endtask

`ifdef RAY_HIT_COUNT_EN
    task automatic test_hit_count();
        do_reset();
        ifc.out_ready = 1'b1;
        set_le(3'b111);
        ifc.in_valid = 1'b1;
        for (int c = 0; c < 70000; c++) begin
            ifc.in_id = 8'(c);
            tick();
        end
        ifc.in_valid = 1'b0;
        repeat (10) tick();
        checks++;
        if (hit_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL hit_count_sat got %h want ffff", hit_count);
        end
        idle();
    endtask
`endif

    initial begin
        idle();
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_overflow();
        test_reset_mid();
`ifdef RAY_HIT_COUNT_EN
        test_hit_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
